// File: rtl/ifu_fetch_ctr_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encodings,
// reset PC and the sequential PC increment.
package ifu_fetch_ctr_pkg;

    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        IF_HOLD = 3'd3,
        IF_TRAP = 3'd4
    } if_state_e;

    localparam logic [63:0] IF_RESET_PC   = 64'h8000_0000;
    localparam int          IF_INST_WIDTH = 32;
    localparam int          IF_PC_INC     = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: branch target when redirected, otherwise sequential PC.
// Also flags a target that is not 4-byte aligned.
module pc_next_sel
    import ifu_fetch_ctr_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                branch_flag,
    input  logic [PC_WIDTH-1:0] branch_dnpc,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                misalign
);

    // Sequential increment wraps silently at 2^PC_WIDTH.
    assign next_pc  = branch_flag ? branch_dnpc : (pc + PC_WIDTH'(IF_PC_INC));
    assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch_ctr.sv
// Instruction-fetch controller and PC owner: one outstanding imem request,
// returned instruction held for decode until it is accepted.
module ifu_fetch_ctr
    import ifu_fetch_ctr_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  INST_WIDTH = IF_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(IF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_branch_flag_i,
    input  logic [PC_WIDTH-1:0]   if_branch_dnpc_i,
    output logic                  if_imem_req_valid_o,
    input  logic                  if_imem_req_ready_i,
    output logic [PC_WIDTH-1:0]   if_imem_addr_o,
    input  logic                  if_imem_resp_valid_i,
    input  logic [INST_WIDTH-1:0] if_imem_rdata_i,
    output logic                  if_inst_valid_o,
    input  logic                  if_inst_ready_i,
    output logic [INST_WIDTH-1:0] if_inst_o,
    output logic [PC_WIDTH-1:0]   if_pc_o,
    output logic                  if_misalign_o
);

    if_state_e             state;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  misalign_q;
    logic [PC_WIDTH-1:0]   next_pc;
    logic                  next_misalign;

    pc_next_sel #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc_next_sel (
        .pc          (pc_q),
        .branch_flag (if_branch_flag_i),
        .branch_dnpc (if_branch_dnpc_i),
        .next_pc     (next_pc),
        .misalign    (next_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IF_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                IF_IDLE: state <= IF_REQ;
                IF_REQ: begin
                    if (if_imem_req_ready_i) state <= IF_WAIT;
                end
                IF_WAIT: begin
                    if (if_imem_resp_valid_i) begin
                        inst_q <= if_imem_rdata_i;
                        state  <= IF_HOLD;
                    end
                end
                IF_HOLD: begin
                    // Redirect inputs only matter on the handoff edge.
                    if (if_inst_ready_i) begin
                        if (next_misalign) begin
                            misalign_q <= 1'b1;
                            state      <= IF_TRAP;
                        end else begin
                            pc_q  <= next_pc;
                            state <= IF_REQ;
                        end
                    end
                end
                IF_TRAP: state <= IF_TRAP;
                default: state <= IF_IDLE;
            endcase
        end
    end

    // Valids come from the state register alone, never from inputs.
    assign if_imem_req_valid_o = (state == IF_REQ);
    assign if_inst_valid_o     = (state == IF_HOLD);
    assign if_imem_addr_o      = pc_q;
    assign if_pc_o             = pc_q;
    assign if_inst_o           = inst_q;
    assign if_misalign_o       = misalign_q;

endmodule

// File: tb/tb_ifu_fetch_ctr.sv
// Directed bench for ifu_fetch_ctr with a one-cycle-latency memory model
// that returns 0x13 + addr[15:0] for each accepted request.
module tb_ifu_fetch_ctr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_flag;
    logic [63:0] branch_dnpc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] addr;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;
    bit auto_mem = 1'b1;

    always #5 clk = ~clk;

    ifu_fetch_ctr dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .if_branch_flag_i     (branch_flag),
        .if_branch_dnpc_i     (branch_dnpc),
        .if_imem_req_valid_o  (req_valid),
        .if_imem_req_ready_i  (req_ready),
        .if_imem_addr_o       (addr),
        .if_imem_resp_valid_i (resp_valid),
        .if_imem_rdata_i      (rdata),
        .if_inst_valid_o      (inst_valid),
        .if_inst_ready_i      (inst_ready),
        .if_inst_o            (inst),
        .if_pc_o              (pc),
        .if_misalign_o        (misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: note an acceptance before the edge, answer it in the next cycle.
    task automatic tick();
        logic        acc;
        logic [63:0] a;
        acc = req_valid && req_ready && rst_n;
        a   = addr;
        @(posedge clk);
        #1;
        if (acc) accepts++;
        if (auto_mem) begin
            resp_valid = acc;
            rdata      = 32'h13 + {16'h0, a[15:0]};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_inst_valid"}, inst_valid, 0);
        check({tag, "_misalign"}, misalign, 0);
        check({tag, "_addr"}, addr, 64'h8000_0000);
        check({tag, "_pc"}, pc, 64'h8000_0000);
        check({tag, "_inst"}, inst, 0);
    endtask

    // Starting in REQ: fetch at a, expect instruction e, hand off with flag/dnpc.
    task automatic run_fetch(input logic [63:0] a, input logic [31:0] e,
                             input logic f, input logic [63:0] d);
        check("req_valid", req_valid, 1);
        check("req_addr", addr, a);
        tick();
        check("wait_no_valid", inst_valid, 0);
        tick();
        check("hold_valid", inst_valid, 1);
        check("hold_pc", pc, a);
        check("hold_inst", inst, e);
        branch_flag = f;
        branch_dnpc = d;
        tick();
        branch_flag = 1'b0;
        branch_dnpc = 64'h0;
    endtask

    initial begin
        int acc0;
        rst_n       = 1'b0;
        branch_flag = 1'b0;
        branch_dnpc = 64'h0;
        req_ready   = 1'b1;
        inst_ready  = 1'b1;
        resp_valid  = 1'b0;
        rdata       = 32'h0;
        repeat (3) tick();
        check_reset_outputs("reset");

        rst_n = 1'b1;
        tick();
        run_fetch(64'h8000_0000, 32'h0000_0013, 1'b0, 64'h0);
        check("cadence_addr", addr, 64'h8000_0004);

        // Request held under memory backpressure.
        req_ready = 1'b0;
        acc0 = accepts;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", req_valid, 1);
            check("bp_addr", addr, 64'h8000_0004);
        end
        check("bp_no_accept", accepts, acc0);
        req_ready = 1'b1;
        run_fetch(64'h8000_0004, 32'h0000_0017, 1'b0, 64'h0);
        check("bp_one_accept", accepts, acc0 + 1);

        run_fetch(64'h8000_0008, 32'h0000_001b, 1'b0, 64'h0);
        run_fetch(64'h8000_000c, 32'h0000_001f, 1'b0, 64'h0);
        run_fetch(64'h8000_0010, 32'h0000_0023, 1'b1, 64'h8000_0100);
        run_fetch(64'h8000_0100, 32'h0000_0113, 1'b0, 64'h0);
        check("seq_after_branch", addr, 64'h8000_0104);

        // Decode stall with a redirect visible only while stalled.
        tick();
        tick();
        inst_ready  = 1'b0;
        branch_flag = 1'b1;
        branch_dnpc = 64'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", inst_valid, 1);
            check("stall_pc", pc, 64'h8000_0104);
            check("stall_inst", inst, 32'h0000_0117);
            check("stall_no_req", req_valid, 0);
        end
        branch_flag = 1'b0;
        inst_ready  = 1'b1;
        tick();
        check("stall_next_addr", addr, 64'h8000_0108);

        // Misaligned redirect traps.
        run_fetch(64'h8000_0108, 32'h0000_011b, 1'b1, 64'h8000_0002);
        check("trap_misalign", misalign, 1);
        check("trap_inst_valid", inst_valid, 0);
        check("trap_pc", pc, 64'h8000_0108);
        acc0 = accepts;
        repeat (5) tick();
        check("trap_sticky", misalign, 1);
        check("trap_no_req", req_valid, 0);
        check("trap_no_accept", accepts, acc0);

        rst_n = 1'b0;
        #1;
        check_reset_outputs("trap_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_addr", addr, 64'h8000_0000);

        // Reset during WAIT, stale response arriving after release.
        auto_mem = 1'b0;
        tick();
        check("wait_state", req_valid, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("wait_reset");
        tick();
        rst_n      = 1'b1;
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        rdata      = 32'hdead_beef;
        tick();
        tick();
        check("stale_req_valid", req_valid, 1);
        check("stale_addr", addr, 64'h8000_0000);
        check("stale_inst_valid", inst_valid, 0);
        check("stale_inst", inst, 0);
        resp_valid = 1'b0;
        auto_mem   = 1'b1;
        req_ready  = 1'b1;
        run_fetch(64'h8000_0000, 32'h0000_0013, 1'b0, 64'h0);
        check("post_reset_next", addr, 64'h8000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctr.md
# ifu_fetch_ctr

Instruction-fetch controller and PC owner. Issues one instruction-memory request at a time and hands each returned instruction and its PC to decode/execute through a valid/ready handshake. It is the consumer of the branch controller's outputs: when an instruction leaves, it takes `branch_flag`/`branch_dnpc` to choose the next PC. It sits between the instruction-memory port and the decode stage of the core.

## Interface
Parameters:
- `PC_WIDTH`, 64, PC and address width (equals `DataBus_WIDTH`)
- `INST_WIDTH`, 32, instruction width
- `RESET_PC`, 64'h8000_0000, first fetch address

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `if_branch_flag_i`  in  1  redirect request for the instruction now on `if_inst_o`; sampled only on a handoff
- `if_branch_dnpc_i`  in  PC_WIDTH  redirect target; sampled only on a handoff
- `if_imem_req_valid_o`  out  1  fetch request valid
- `if_imem_req_ready_i`  in  1  memory accepts the request
- `if_imem_addr_o`  out  PC_WIDTH  fetch address
- `if_imem_resp_valid_i`  in  1  read data valid
- `if_imem_rdata_i`  in  INST_WIDTH  read data
- `if_inst_valid_o`  out  1  instruction available to decode
- `if_inst_ready_i`  in  1  decode accepts the instruction
- `if_inst_o`  out  INST_WIDTH  held instruction
- `if_pc_o`  out  PC_WIDTH  PC of `if_inst_o`
- `if_misalign_o`  out  1  sticky flag: misaligned redirect target

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, TRAP.
- Registers: `pc_q` (PC_WIDTH), `inst_q` (INST_WIDTH), the state register, and a sticky misalign bit.
- IDLE:
  - Reset state.
  - Moves to REQ unconditionally on the next edge.
- REQ:
  - `if_imem_req_valid_o`=1 and `if_imem_addr_o`=`pc_q`.
  - Both stay stable until `if_imem_req_ready_i`=1; on that edge, move to WAIT.
- WAIT:
  - On `if_imem_resp_valid_i`=1: `inst_q` <= `if_imem_rdata_i`, then move to HOLD.
  - `if_imem_resp_valid_i` is ignored in every other state.
- HOLD:
  - `if_inst_valid_o`=1, `if_inst_o`=`inst_q`, `if_pc_o`=`pc_q`.
  - Handoff is the edge where `if_inst_ready_i`=1.
  - On handoff, next PC = `if_branch_dnpc_i` if `if_branch_flag_i`=1, otherwise `pc_q`+4. Addition is modulo 2^PC_WIDTH, so wrap-around is silent.
  - If next PC[1:0] != 0, `pc_q` is not updated, the misalign bit is set, and the FSM moves to TRAP. Otherwise `pc_q` <= next PC and the FSM moves to REQ.
- TRAP:
  - No requests; `if_inst_valid_o`=0; `if_misalign_o`=1.
  - Left only by reset.
- Valid outputs are decoded from registered state only. There is no combinational path from any input to any valid output.
- Redirect inputs are don't-care outside HOLD-with-ready.

## Timing
- Reset values (held while `rst_n`=0): state IDLE, `pc_q`=`RESET_PC`, `inst_q`=0, `if_imem_req_valid_o`=0, `if_inst_valid_o`=0, `if_misalign_o`=0, `if_imem_addr_o`=`RESET_PC`, `if_pc_o`=`RESET_PC`, `if_inst_o`=0.
- First request is visible on the 2nd rising edge after `rst_n` rises (IDLE, then REQ).
- Memory contract:
  - At most one outstanding request.
  - The response arrives no earlier than the cycle after acceptance.
  - Memory backpressure is unbounded.
- Latency: request accepted at edge N, response at edge ≥N+1, `if_inst_valid_o` high from after edge N+1.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD), with all readies and response valid tied high.
- Reset asserted mid-WAIT or mid-HOLD:
  - The FSM returns to IDLE immediately.
  - Any later stale response is ignored, because it arrives outside WAIT.
  - Fetch restarts at `RESET_PC`.

## Structure
- Add to the shared defines file:
  - FSM state encodings (3-bit): `IF_IDLE`, `IF_REQ`, `IF_WAIT`, `IF_HOLD`, `IF_TRAP`
  - `RESET_PC` default
  - `INST_WIDTH`
  - `PC_INC`=4
- One sub-module is natural: `pc_next_sel`. It is combinational and takes `pc_q`, the flag and the target, producing the next PC and a misalign indication. It is kept separate so it can be unit-tested against the branch controller's outputs.

## Test plan
- Reset release with all readies high, memory returning data 0x00000013 one cycle after acceptance -> first `if_imem_addr_o`=0x8000_0000; `if_inst_valid_o` with `if_pc_o`=0x8000_0000, `if_inst_o`=0x00000013; next request at 0x8000_0004; 3-cycle cadence.
- Handoff at PC 0x8000_0010 with flag=1 and dnpc=0x8000_0100 -> next request address 0x8000_0100; the following sequential request is 0x8000_0104.
- `if_imem_req_ready_i` low for 5 cycles in REQ -> valid and address 0x8000_0004 stay stable for those 5 cycles; exactly one acceptance.
- `if_inst_ready_i` low for 4 cycles in HOLD; flag=1 during the stall, then flag=0 at handoff -> outputs stable during the stall; next PC = `pc_q`+4 (flag is sampled only at handoff).
- Handoff with flag=1 and dnpc=0x8000_0002 -> `if_misalign_o`=1 next cycle; no further requests; `if_pc_o` unchanged; cleared only by `rst_n`.
- `rst_n` pulsed low during WAIT, with the response arriving after reset is released -> response ignored; outputs at reset values; fetch restarts at 0x8000_0000.
